full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
// PURPOSE
// - Binary full subtractor: diff = a - b - bin, with borrow-out, in the arithmetic-circuits library.
// - Default build is a 1-bit cell.
// - WIDTH > 1 builds a ripple-borrow subtractor for datapath use.
// - Combinational result paths give zero-latency use.
// - A registered copy with valid tracking serves pipelined consumers.
// PARAMETERS
// - WIDTH  1  operand width in bits (>= 1)
// PORTS
// - clk       input   1      single clock; all state on rising edge
// - rst       input   1      synchronous, active-high reset
// - a         input   WIDTH  minuend
// - b         input   WIDTH  subtrahend
// - bin       input   1      borrow-in
// - in_valid  input   1      qualifies a/b/bin for the registered stage
// - diff      output  WIDTH  combinational difference
// - bout      output  1      combinational borrow-out
// - diff_q    output  WIDTH  registered difference
// - bout_q    output  1      registered borrow-out
// - out_valid output  1      diff_q/bout_q hold a valid result
// BEHAVIOUR
// - Interface: one clock (clk); reset rst is synchronous and active-high.
// - Per-bit cell i, with borrow chain c[0] = bin:
//   - d[i]   = a[i] ^ b[i] ^ c[i]
//   - c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i])
// - diff = d[WIDTH-1:0]; bout = c[WIDTH].
// - Result is exactly {bout, diff} = a - b - bin modulo 2^(WIDTH+1).
// - bout = 1 iff a < b + bin (unsigned).
// - diff/bout are purely combinational.
//   - They settle within the same cycle as an input change.
//   - They are independent of clk/rst and are never reset.
// - Registered stage, 1-cycle latency:
//   - On a clk rise with in_valid = 1: diff_q <= diff, bout_q <= bout, out_valid <= 1.
//   - With in_valid = 0: diff_q/bout_q hold their value; out_valid <= 0.
// - Reset: rst = 1 at a clk rise forces diff_q = 0, bout_q = 0, out_valid = 0.
//   - rst overrides a simultaneous in_valid.
//   - Reset mid-stream discards the in-flight result.
//   - The first capture after reset release occurs on the next rise with in_valid = 1.
// - Boundary cases:
//   - a = 0, b = all-ones, bin = 1 -> diff = 0, bout = 1 (full wrap).
//   - a = b, bin = 0 -> diff = 0, bout = 0.
// - No X-propagation masking; no internal state beyond the three registers.
// STRUCTURE
// - Shared package: none required.
//   - WIDTH stays a local parameter.
//   - The borrow equations are not exported.
// - One sub-module: full_sub_cell (a, b, bin -> d, bo), 1-bit, combinational.
//   - Instantiated WIDTH times via generate, borrow chained LSB to MSB.
// - Top adds the output register and valid flop only.
// TESTING
// - Exhaustive 1-bit truth table, combinational, 10 time units per vector; {a,b,bin} -> {diff,bout}:
//   - 000->00, 001->11, 010->11, 011->01
//   - 100->10, 101->00, 110->00, 111->11
// - Registered path:
//   - Reset asserted 2 cycles -> diff_q = 0, bout_q = 0, out_valid = 0.
//   - Then a=1, b=0, bin=0, in_valid=1 -> next cycle diff_q = 1, bout_q = 0, out_valid = 1.
// - Hold: in_valid = 0 while inputs change to 111 -> diff_q/bout_q unchanged; out_valid = 0.
// - Reset priority: rst = 1 with in_valid = 1 and inputs 011 -> next cycle all registered outputs 0.
// - WIDTH = 8, random plus corners:
//   - a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
//   - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0.
//   - Compare against {bout,diff} = a - b - bin.

Source files
------------

// File: rtl/full_subtractor_pkg.sv
// Shared constants for the full subtractor slice.
package full_subtractor_pkg;

    // Default operand width: a single-bit subtractor cell.
    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell: d = a ^ b ^ bin, borrow out when a < b + bin.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic axb;

    // Difference bit and borrow generate/propagate for this position.
    always_comb begin
        axb = a ^ b;
        d   = axb ^ bin;
        bo  = (~a & b) | (~axb & bin);
    end

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor with a combinational result and a registered,
// valid-qualified copy for pipelined consumers.
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [WIDTH-1:0] diff_q,
    output logic             bout_q,
    output logic             out_valid
);

    // Borrow chain: brw[0] is the external borrow-in, brw[WIDTH] the borrow-out.
    logic [WIDTH:0] brw;

    assign brw[0] = bin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_sub_cell u_cell (
                .a   (a[i]),
                .b   (b[i]),
                .bin (brw[i]),
                .d   (diff[i]),
                .bo  (brw[i+1])
            );
        end
    endgenerate

    assign bout = brw[WIDTH];

    logic [WIDTH-1:0] diff_q_d, diff_q_q;
    logic             bout_q_d, bout_q_q;
    logic             out_valid_d, out_valid_q;

    // Capture on a valid input; otherwise hold the data and drop valid.
    always_comb begin
        diff_q_d    = diff_q_q;
        bout_q_d    = bout_q_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            diff_q_d    = diff;
            bout_q_d    = bout;
            out_valid_d = 1'b1;
        end
    end

    // Output register; reset wins over a simultaneous capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q_q    <= '0;
            bout_q_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            diff_q_q    <= diff_q_d;
            bout_q_q    <= bout_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign diff_q    = diff_q_q;
    assign bout_q    = bout_q_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for the full subtractor: 1-bit truth table, registered
// path behaviour, and an 8-bit instance with corners and random vectors.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 1-bit instance
    logic       a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0, iv1 = 1'b0;
    logic       diff1, bout1, diff1_q, bout1_q, ov1;

    // 8-bit instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0, iv8 = 1'b0;
    logic [7:0] diff8, diff8_q;
    logic       bout8, bout8_q, ov8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .bin(bin1), .in_valid(iv1),
        .diff(diff1), .bout(bout1), .diff_q(diff1_q), .bout_q(bout1_q), .out_valid(ov1)
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .in_valid(iv8),
        .diff(diff8), .bout(bout8), .diff_q(diff8_q), .bout_q(bout8_q), .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hand-computed {diff,bout} per {a,b,bin}
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        logic [2:0] v;
        logic [8:0] exp9;

        // Exhaustive 1-bit truth table, 10 time units per vector
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, bin1} = v;
            #5;
            chk($sformatf("tt%0d", i), {30'd0, diff1, bout1}, {30'd0, tt[i]});
            #5;
        end

        // Reset held for two cycles
        @(negedge clk);
        rst = 1'b1; iv1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regs", {29'd0, diff1_q, bout1_q, ov1}, 32'd0);
        chk("rst_regs8", {23'd0, diff8_q, ov8}, 32'd0);

        // First capture after release
        @(negedge clk);
        rst = 1'b0; {a1, b1, bin1} = 3'b100; iv1 = 1'b1;
        @(posedge clk); #1;
        chk("cap_diff", {31'd0, diff1_q}, 32'd1);
        chk("cap_bout", {31'd0, bout1_q}, 32'd0);
        chk("cap_vld",  {31'd0, ov1},     32'd1);

        // Hold while inputs change with in_valid low
        @(negedge clk);
        iv1 = 1'b0; {a1, b1, bin1} = 3'b111;
        @(posedge clk); #1;
        chk("hold_regs", {29'd0, diff1_q, bout1_q, ov1}, {29'd0, 3'b100});
        chk("hold_comb", {30'd0, diff1, bout1}, 32'd3);

        // Capture then reset with in_valid high: reset wins
        @(negedge clk);
        iv1 = 1'b1; {a1, b1, bin1} = 3'b111;
        @(posedge clk); #1;
        chk("cap111", {29'd0, diff1_q, bout1_q, ov1}, 32'd7);
        @(negedge clk);
        rst = 1'b1; {a1, b1, bin1} = 3'b011;
        @(posedge clk); #1;
        chk("rst_prio", {29'd0, diff1_q, bout1_q, ov1}, 32'd0);

        // Release with in_valid low: nothing captured yet
        @(negedge clk);
        rst = 1'b0; iv1 = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {29'd0, diff1_q, bout1_q, ov1}, 32'd0);
        @(negedge clk);
        iv1 = 1'b1; {a1, b1, bin1} = 3'b011;
        @(posedge clk); #1;
        chk("post_rst_cap", {29'd0, diff1_q, bout1_q, ov1}, 32'd3);
        @(negedge clk);
        iv1 = 1'b0;

        // 8-bit corners
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; #1;
        chk("w8_wrap", {23'd0, bout8, diff8}, {23'd0, 1'b1, 8'h00});
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; #1;
        chk("w8_80m01", {23'd0, bout8, diff8}, {23'd0, 1'b0, 8'h7F});
        a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b0; #1;
        chk("w8_eq", {23'd0, bout8, diff8}, 32'd0);
        a8 = 8'h5A; b8 = 8'h5A; bin8 = 1'b1; #1;
        chk("w8_eq_bin", {23'd0, bout8, diff8}, {23'd0, 1'b1, 8'hFF});

        // 8-bit registered capture of 0x80 - 0x01
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        chk("w8_reg", {22'd0, ov8, bout8_q, diff8_q}, {22'd0, 2'b10, 8'h7F});
        @(negedge clk);
        iv8 = 1'b0;

        // 8-bit random against arithmetic reference
        for (int i = 0; i < 40; i++) begin
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            bin8 = 1'($urandom_range(0, 1));
            exp9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
            #1;
            chk($sformatf("w8_rnd%0d", i), {23'd0, bout8, diff8}, {23'd0, exp9});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
